// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared address map, FSM state and decode-target types
package dmem_pkg;

  localparam logic [31:0] RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] LED_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] SW_ADDR  = 32'hFFFF_0004;
  localparam logic [31:0] CYC_ADDR = 32'hFFFF_0008;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  typedef enum logic [1:0] {T_RAM, T_LED, T_SW, T_CYC} dmem_tgt_t;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core load/store port with req/ready handshake
interface dmem_responder_if;

  logic        MemReq;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        AddrErr;

  modport master (
    output MemReq, MemWrite, Addr, WriteData,
    input  ReadData, MemReady, AddrErr
  );

  modport slave (
    input  MemReq, MemWrite, Addr, WriteData,
    output ReadData, MemReady, AddrErr
  );

endinterface

// File: rtl/dmem_responder_sp_ram.sv
// rtl/dmem_responder_sp_ram.sv - single-port word RAM, synchronous read-first and write
module sp_ram #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: RAM + LED/SW/CYC registers, wait states, error flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int RAM_WORDS   = 1024
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  input  logic [7:0]        sw_in,
  output logic [7:0]        led_out
);

  localparam int          AW     = $clog2(RAM_WORDS);
  localparam logic [3:0]  W_LAST = 4'(WAIT_CYCLES - 1);

  dmem_state_t   state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [AW-1:0] ridx_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic          err_q;
  dmem_tgt_t     tgt_q;
  logic [31:0]   rdata_q;
  logic [31:0]   cyc_q;
  logic [7:0]    led_q;
  logic [7:0]    sw_meta_q, sw_sync_q;

  dmem_tgt_t     tgt_in;
  logic          err_in;
  logic [31:0]   resp_data;
  logic [31:0]   ram_q;
  logic [AW-1:0] ram_addr;
  logic          ram_we;

  always_comb begin
    tgt_in = T_RAM;
    err_in = 1'b0;
    if (bus.Addr[1:0] != 2'b00) begin
      err_in = 1'b1;
    end else if (bus.Addr[31:AW+2] == RAM_BASE[31:AW+2]) begin
      tgt_in = T_RAM;
    end else if (bus.Addr == LED_ADDR) begin
      tgt_in = T_LED;
    end else if (bus.Addr == SW_ADDR) begin
      tgt_in = T_SW;
    end else if (bus.Addr == CYC_ADDR) begin
      tgt_in = T_CYC;
    end else begin
      err_in = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (bus.MemReq) begin
          wcnt_d  = 4'd0;
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (wcnt_q == W_LAST) begin
          state_d = RESP;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM reads every cycle; the word seen during RESP was addressed the cycle before.
  assign ram_addr = (state_q == IDLE) ? bus.Addr[AW+1:2] : ridx_q;
  assign ram_we   = (state_q == RESP) && we_q && !err_q && (tgt_q == T_RAM);

  sp_ram #(.WORDS(RAM_WORDS), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_q)
  );

  always_comb begin
    resp_data = rdata_q;
    if (err_q) begin
      resp_data = 32'd0;
    end else if (!we_q) begin
      case (tgt_q)
        T_RAM:   resp_data = ram_q;
        T_LED:   resp_data = {24'd0, led_q};
        T_SW:    resp_data = {24'd0, sw_sync_q};
        default: resp_data = cyc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wcnt_q    <= 4'd0;
      ridx_q    <= '0;
      wdata_q   <= 32'd0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      tgt_q     <= T_RAM;
      rdata_q   <= 32'd0;
      cyc_q     <= 32'd0;
      led_q     <= 8'd0;
      sw_meta_q <= 8'd0;
      sw_sync_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
      cyc_q     <= cyc_q + 32'd1;
      if (state_q == IDLE && bus.MemReq) begin
        ridx_q  <= bus.Addr[AW+1:2];
        wdata_q <= bus.WriteData;
        we_q    <= bus.MemWrite;
        err_q   <= err_in;
        tgt_q   <= tgt_in;
      end
      if (state_q == RESP) begin
        rdata_q <= resp_data;
        if (we_q && !err_q) begin
          if (tgt_q == T_LED) led_q <= wdata_q[7:0];
          if (tgt_q == T_CYC) cyc_q <= 32'd0;
        end
      end
    end
  end

  assign bus.MemReady = (state_q == RESP);
  assign bus.AddrErr  = (state_q == RESP) && err_q;
  assign bus.ReadData = (state_q == RESP) ? resp_data : rdata_q;
  assign led_out      = led_q;

endmodule
